// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one single-port synchronous memory between the instruction-fetch
//   requester (if_*) and the load/store requester (d_*). One transaction is
//   outstanding at a time. The fixed memory read latency is sequenced here, and
//   read data is returned from registers.
//
//   Build option: ARB_ROUND_ROBIN_EN
//     defined   - simultaneous requests alternate winners. Data wins first after
//                 reset.
//     undefined - data has fixed priority. Fetch is forced to win after
//                 STARVE_MAX consecutive losses.
//
//   Ports
//     clk_i, rst_ni                    rising-edge clock, async active-low reset
//     if_req_i, if_addr_i              fetch request / address
//     if_gnt_o                         fetch grant (combinational, IDLE only)
//     if_rvalid_o, if_rdata_o          fetch response pulse / registered data
//     d_req_i, d_we_i, d_addr_i,
//     d_wdata_i                        data request, 1=store, address, store data
//     d_gnt_o                          data grant (combinational, IDLE only)
//     d_rvalid_o, d_rdata_o            data response pulse / registered data
//                                      (d_rdata_o is 0 for stores)
//     mem_en_o, mem_we_o,
//     mem_addr_o, mem_wdata_o          memory strobe, write enable, address and
//                                      write data; all are 0 outside a grant cycle
//     mem_rdata_i                      memory read data, valid MEM_LAT cycles
//                                      after mem_en_o
//
//   state  | meaning
//   IDLE   | accept and grant one request, then strobe the memory
//   WAIT   | count down the memory latency, then capture read data
//   RESP   | pulse the winner's rvalid for one cycle
module mem_port_arbiter #(
  parameter int unsigned AW         = 32,
  parameter int unsigned DW         = 32,
  parameter int unsigned MEM_LAT    = 1,
  parameter int unsigned STARVE_MAX = 3
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          if_req_i,
  input  logic [AW-1:0] if_addr_i,
  output logic          if_gnt_o,
  output logic          if_rvalid_o,
  output logic [DW-1:0] if_rdata_o,
  input  logic          d_req_i,
  input  logic          d_we_i,
  input  logic [AW-1:0] d_addr_i,
  input  logic [DW-1:0] d_wdata_i,
  output logic          d_gnt_o,
  output logic          d_rvalid_o,
  output logic [DW-1:0] d_rdata_o,
  output logic          mem_en_o,
  output logic          mem_we_o,
  output logic [AW-1:0] mem_addr_o,
  output logic [DW-1:0] mem_wdata_o,
  input  logic [DW-1:0] mem_rdata_i
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_e;

  localparam int unsigned LW = 2;
  localparam logic [LW-1:0] LAT_INIT = LW'(MEM_LAT - 1);

  state_e        state_q, state_d;
  logic [LW-1:0] lat_q, lat_d;
  logic          win_d_q, win_d_d;   // 1: data requester owns the transaction
  logic          store_q, store_d;
  logic [DW-1:0] if_rdata_q, if_rdata_d;
  logic [DW-1:0] d_rdata_q, d_rdata_d;
  logic          grant_if, grant_d, pick_d;

`ifdef ARB_ROUND_ROBIN_EN
  logic          last_d_q, last_d_d; // last grant went to data
`else
  localparam int unsigned SW = (STARVE_MAX < 2) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);
  logic [SW-1:0] starve_q, starve_d;
`endif

  always_comb begin
    state_d    = state_q;
    lat_d      = lat_q;
    win_d_d    = win_d_q;
    store_d    = store_q;
    if_rdata_d = if_rdata_q;
    d_rdata_d  = d_rdata_q;
    grant_if   = 1'b0;
    grant_d    = 1'b0;
    pick_d     = 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
    last_d_d   = last_d_q;
`else
    starve_d   = starve_q;
`endif

    case (state_q)
      S_IDLE: begin
`ifdef ARB_ROUND_ROBIN_EN
        pick_d = (if_req_i && d_req_i) ? !last_d_q : d_req_i;
`else
        pick_d = (if_req_i && d_req_i) ? (starve_q != STARVE_LIM) : d_req_i;
        // Only a data win against a waiting fetch counts as a fetch loss.
        // A loss at the limit cannot occur, because fetch wins there.
        if (if_req_i && d_req_i && pick_d) starve_d = starve_q + 1'b1;
        else                               starve_d = '0;
`endif
        // Grants are held off while reset is asserted, so reset never
        // strobes the memory.
        if (rst_ni && (if_req_i || d_req_i)) begin
          grant_d  = pick_d;
          grant_if = !pick_d;
          win_d_d  = pick_d;
          store_d  = pick_d && d_we_i;
          lat_d    = LAT_INIT;
          state_d  = S_WAIT;
`ifdef ARB_ROUND_ROBIN_EN
          last_d_d = pick_d;
`endif
        end
      end
      S_WAIT: begin
        if (lat_q == '0) begin
          if (win_d_q) d_rdata_d  = store_q ? '0 : mem_rdata_i;
          else         if_rdata_d = mem_rdata_i;
          state_d = S_RESP;
        end else begin
          lat_d = lat_q - 1'b1;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= S_IDLE;
      lat_q      <= '0;
      win_d_q    <= 1'b0;
      store_q    <= 1'b0;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
`ifdef ARB_ROUND_ROBIN_EN
      last_d_q   <= 1'b0;
`else
      starve_q   <= '0;
`endif
    end else begin
      state_q    <= state_d;
      lat_q      <= lat_d;
      win_d_q    <= win_d_d;
      store_q    <= store_d;
      if_rdata_q <= if_rdata_d;
      d_rdata_q  <= d_rdata_d;
`ifdef ARB_ROUND_ROBIN_EN
      last_d_q   <= last_d_d;
`else
      starve_q   <= starve_d;
`endif
    end
  end

  assign if_gnt_o    = grant_if;
  assign d_gnt_o     = grant_d;
  assign mem_en_o    = grant_if | grant_d;
  assign mem_we_o    = grant_d & d_we_i;
  assign mem_addr_o  = grant_d ? d_addr_i : (grant_if ? if_addr_i : '0);
  assign mem_wdata_o = grant_d ? d_wdata_i : '0;
  assign if_rvalid_o = (state_q == S_RESP) && !win_d_q;
  assign d_rvalid_o  = (state_q == S_RESP) && win_d_q;
  assign if_rdata_o  = if_rdata_q;
  assign d_rdata_o   = d_rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
//   Directed and random stimulus for mem_port_arbiter (MEM_LAT=2, STARVE_MAX=2).
//   A transaction-level model predicts every output on every cycle. The model
//   tracks one outstanding transaction with a countdown to its response, and
//   owns the memory contents.
module tb_mem_port_arbiter;
  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int LAT  = 2;
  localparam int SMAX = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic          if_req, if_gnt, if_rvalid;
  logic [AW-1:0] if_addr;
  logic [DW-1:0] if_rdata;
  logic          d_req, d_we, d_gnt, d_rvalid;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata, d_rdata;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;

  mem_port_arbiter #(.AW(AW), .DW(DW), .MEM_LAT(LAT), .STARVE_MAX(SMAX)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .if_req_i(if_req), .if_addr_i(if_addr), .if_gnt_o(if_gnt),
    .if_rvalid_o(if_rvalid), .if_rdata_o(if_rdata),
    .d_req_i(d_req), .d_we_i(d_we), .d_addr_i(d_addr), .d_wdata_i(d_wdata),
    .d_gnt_o(d_gnt), .d_rvalid_o(d_rvalid), .d_rdata_o(d_rdata),
    .mem_en_o(mem_en), .mem_we_o(mem_we), .mem_addr_o(mem_addr),
    .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] mem [16];
  bit          busy;
  int          rem;
  bit          p_d, p_we;
  logic [31:0] p_data;
  int          starve;
  bit          last_d;
  logic [31:0] e_if_rdata, e_d_rdata;

  int    cyc;
  int    if_gnt_cyc, if_rv_cyc, d_gnt_cyc, d_rv_cyc, if_rv_cnt, d_rv_cnt;
  string order;
  bit    hold_if, hold_d, saw_if_gnt, saw_d_gnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic check_cycle();
    bit          wf, wd, e_ifrv, e_drv;
    logic [31:0] e_addr, e_wdata;
    wf = 0; wd = 0; e_ifrv = 0; e_drv = 0; e_addr = '0; e_wdata = '0;
    // The memory drives the outstanding load's data only in the cycle MEM_LAT
    // after the strobe. In every other cycle it drives noise.
    if (busy && rem == 1 && !p_we) mem_rdata = p_data;
    else                           mem_rdata = $urandom;

    if (!rst_n) begin
      busy = 0; starve = 0; last_d = 0; e_if_rdata = '0; e_d_rdata = '0;
    end else if (busy) begin
      if (rem == 0) begin
        if (p_d) begin e_drv = 1; e_d_rdata = p_we ? 32'h0 : p_data; end
        else begin e_ifrv = 1; e_if_rdata = p_data; end
      end
    end else begin
`ifdef ARB_ROUND_ROBIN_EN
      if (if_req && d_req) begin wd = !last_d; wf = last_d; end
      else begin wd = d_req; wf = if_req; end
      if (wd || wf) last_d = wd;
`else
      if (if_req && d_req) begin
        if (starve == SMAX) begin wf = 1; starve = 0; end
        else begin wd = 1; starve = starve + 1; end
      end else begin
        wf = if_req; wd = d_req; starve = 0;
      end
`endif
      if (wd || wf) begin
        busy = 1; rem = LAT + 1; p_d = wd; p_we = wd && d_we;
        e_addr  = wd ? d_addr : if_addr;
        e_wdata = wd ? d_wdata : 32'h0;
        if (p_we) begin mem[e_addr[5:2]] = d_wdata; p_data = '0; end
        else p_data = mem[e_addr[5:2]];
      end
    end

    chk("if_gnt", if_gnt, wf);
    chk("d_gnt", d_gnt, wd);
    chk("mem_en", mem_en, wf | wd);
    chk("mem_we", mem_we, wd & d_we);
    chk("mem_addr", mem_addr, e_addr);
    chk("mem_wdata", mem_wdata, e_wdata);
    chk("if_rvalid", if_rvalid, e_ifrv);
    chk("d_rvalid", d_rvalid, e_drv);
    chk("if_rdata", if_rdata, e_if_rdata);
    chk("d_rdata", d_rdata, e_d_rdata);

    saw_if_gnt = if_gnt;
    saw_d_gnt  = d_gnt;
    if (if_gnt)    begin order = {order, "F"}; if_gnt_cyc = cyc; end
    if (d_gnt)     begin order = {order, "D"}; d_gnt_cyc = cyc; end
    if (if_rvalid) begin if_rv_cnt++; if_rv_cyc = cyc; end
    if (d_rvalid)  begin d_rv_cnt++; d_rv_cyc = cyc; end

    if (busy) begin
      if (rem == 0) busy = 0;
      else          rem--;
    end
    cyc++;
  endtask

  task automatic tick();
    @(negedge clk);
    check_cycle();
    @(posedge clk);
    #1;
    if (!hold_if && saw_if_gnt) if_req = 1'b0;
    if (!hold_d && saw_d_gnt)   d_req  = 1'b0;
  endtask

  task automatic rand_drive();
    if (!if_req && $urandom_range(0, 2) == 0) begin
      if_req = 1'b1; if_addr = $urandom;
    end else if (if_req && $urandom_range(0, 19) == 0) begin
      if_req = 1'b0;
    end
    if (!d_req && $urandom_range(0, 2) == 0) begin
      d_req = 1'b1; d_we = $urandom_range(0, 1) == 1; d_addr = $urandom; d_wdata = $urandom;
    end else if (d_req && $urandom_range(0, 19) == 0) begin
      d_req = 1'b0;
    end
  endtask

  initial begin : main
    int    rel_cyc, rv_before;
    string exp_order;
    for (int i = 0; i < 16; i++) mem[i] = $urandom;
    mem[4] = 32'h00500113;
    busy = 0; rem = 0; p_d = 0; p_we = 0; p_data = '0; starve = 0; last_d = 0;
    e_if_rdata = '0; e_d_rdata = '0; cyc = 0; order = "";
    if_gnt_cyc = -100; if_rv_cyc = -100; d_gnt_cyc = -100; d_rv_cyc = -100;
    if_rv_cnt = 0; d_rv_cnt = 0; hold_if = 0; hold_d = 0;
    rst_n = 1'b0; mem_rdata = '0;
    if_req = 1'b1; if_addr = 32'h14;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h1B; d_wdata = 32'h0;
    @(posedge clk); #1;

    // Reset held with both requests high: every output stays 0
    repeat (3) tick();

    // Release: data wins first (load 0x1B), fetch wins at the next IDLE cycle
    rst_n = 1'b1; order = ""; rel_cyc = cyc;
    repeat (2 * (LAT + 2)) tick();
    chk("t1_first_gnt_cycle", d_gnt_cyc, rel_cyc);
    n_checks++;
    assert (order == "DF")
    else begin n_fail++; $error("FAIL t3_order: observed %s expected DF", order); end

    // Single fetch at 0x10: rvalid exactly 3 cycles after the grant
    if_req = 1'b1; if_addr = 32'h10; rv_before = if_rv_cnt;
    repeat (LAT + 4) tick();
    chk("t2_latency", if_rv_cyc - if_gnt_cyc, 3);
    chk("t2_rdata", if_rdata, 32'h00500113);
    chk("t2_pulses", if_rv_cnt - rv_before, 1);

    // Store, then read it back
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h20; d_wdata = 32'h10FEDE01;
    repeat (LAT + 3) tick();
    chk("t5_latency", d_rv_cyc - d_gnt_cyc, LAT + 1);
    chk("t5_store_rdata", d_rdata, 32'h0);
    chk("t5_if_rdata_kept", if_rdata, 32'h00500113);
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h20;
    repeat (LAT + 3) tick();
    chk("t5_readback", d_rdata, 32'h10FEDE01);

    // Reset pulsed during WAIT drops the fetch, and the next fetch proceeds normally
    if_req = 1'b1; if_addr = 32'h18; rv_before = if_rv_cnt;
    tick(); tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    repeat (LAT + 4) tick();
    chk("t6_no_rvalid", if_rv_cnt, rv_before);
    chk("t6_rdata_cleared", if_rdata, 32'h0);
    if_req = 1'b1; if_addr = 32'h10;
    repeat (LAT + 4) tick();
    chk("t6_latency_after", if_rv_cyc - if_gnt_cyc, 3);
    chk("t6_rdata_after", if_rdata, 32'h00500113);

    // Fresh reset, then both requesters held high continuously
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    hold_if = 1; hold_d = 1; if_req = 1'b1; d_req = 1'b1; d_we = 1'b0;
    if_addr = 32'h10; d_addr = 32'h1B; order = "";
    repeat (6 * (LAT + 2)) tick();
`ifdef ARB_ROUND_ROBIN_EN
    exp_order = "DFDFDF";
`else
    exp_order = "DDFDDF";
`endif
    n_checks++;
    assert (order == exp_order)
    else begin n_fail++; $error("FAIL t4_order: observed %s expected %s", order, exp_order); end
    hold_if = 0; hold_d = 0; if_req = 1'b0; d_req = 1'b0;
    repeat (LAT + 3) tick();

    // Random traffic with drops, against the model
    repeat (600) begin
      rand_drive();
      tick();
    end
    if_req = 1'b0; d_req = 1'b0;
    repeat (LAT + 4) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
